// File: rtl/ifu_prefetch.sv
// ifu_prefetch: sequential instruction fetch with a DEPTH-entry prefetch queue,
// variable-latency memory side and redirect flush.
module ifu_prefetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          IM_AW    = 8
) (
    input  logic             clk,
    input  logic             rst,
    output logic             im_req,
    output logic [IM_AW-1:0] im_addr,
    input  logic [31:0]      im_rdata,
    input  logic             im_valid,
    input  logic             redirect,
    input  logic [31:0]      redirect_pc,
    output logic             inst_valid,
    output logic [31:0]      inst,
    output logic [31:0]      inst_pc,
    input  logic             inst_ready
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t           state, state_nxt;
    logic [31:0]      fetch_pc, fetch_pc_nxt;
    logic [PW:0]      count, count_pop, count_nxt;
    logic [PW-1:0]    rd_ptr, wr_ptr, rd_nxt;
    logic [31:0]      q_inst [DEPTH];
    logic [31:0]      q_pc   [DEPTH];
    logic [IM_AW-1:0] req_addr, cur_addr;
    logic [31:0]      head_inst_nxt, head_pc_nxt;
    logic             push, pop;

    assign cur_addr   = IM_AW'((fetch_pc - RESET_PC) >> 2);
    assign inst_valid = count != '0;
    assign im_addr    = im_req ? cur_addr : req_addr;

    always_comb begin
        push         = (state == WAIT) && im_valid && !redirect;
        pop          = inst_valid && inst_ready && !redirect;
        im_req       = rst && (state == IDLE) && (count < FULL) && !redirect;
        count_pop    = count - (PW+1)'(pop);
        count_nxt    = redirect ? '0 : count_pop + (PW+1)'(push);
        rd_nxt       = rd_ptr + PW'(pop);
        fetch_pc_nxt = redirect ? (redirect_pc & ~32'h3) : push ? fetch_pc + 32'd4 : fetch_pc;
        state_nxt    = state;
        case (state)
            IDLE:    state_nxt = im_req ? WAIT : IDLE;
            WAIT:    state_nxt = im_valid ? IDLE : redirect ? DROP : WAIT;
            DROP:    state_nxt = im_valid ? IDLE : DROP;
            default: state_nxt = IDLE;
        endcase
    end

    // Head registers only move when the queue stays non-empty, so they hold while empty.
    always_comb begin
        head_inst_nxt = inst;
        head_pc_nxt   = inst_pc;
        if (!redirect && count_nxt != '0) begin
            head_inst_nxt = (count_pop == '0) ? im_rdata : q_inst[rd_nxt];
            head_pc_nxt   = (count_pop == '0) ? fetch_pc : q_pc[rd_nxt];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            req_addr <= '0;
            inst     <= '0;
            inst_pc  <= '0;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            count    <= count_nxt;
            rd_ptr   <= redirect ? '0 : rd_nxt;
            wr_ptr   <= redirect ? '0 : wr_ptr + PW'(push);
            req_addr <= im_req ? cur_addr : req_addr;
            inst     <= head_inst_nxt;
            inst_pc  <= head_pc_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && push) begin
            q_inst[wr_ptr] <= im_rdata;
            q_pc[wr_ptr]   <= fetch_pc;
        end
    end
endmodule

// File: tb/tb_ifu_prefetch.sv
// tb_ifu_prefetch: directed plan steps plus random traffic against a queue-based
// model of the fetch stream.
module tb_ifu_prefetch;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    logic        clk = 0, rst = 0, im_valid = 0, redirect = 0, inst_ready = 0;
    logic        im_req, inst_valid;
    logic [7:0]  im_addr;
    logic [31:0] im_rdata = 0, redirect_pc = 0, inst, inst_pc;

    int          n_cmp = 0, n_bad = 0, cyc_n = 0, lat = 1, mresp = 0, first = -1;
    logic        mbusy = 0, done;
    logic [7:0]  maddr = 0;
    logic [63:0] m_q [$];
    logic [31:0] m_pc = RESET_PC;
    logic        m_out = 0, m_drop = 0;
    logic [7:0]  req_q [$];
    logic [31:0] acc_pc [$], acc_in [$];

    ifu_prefetch dut (
        .clk(clk), .rst(rst), .im_req(im_req), .im_addr(im_addr), .im_rdata(im_rdata),
        .im_valid(im_valid), .redirect(redirect), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] addr_of(input logic [31:0] pc);
        return 8'((pc - RESET_PC) >> 2);
    endfunction

    function automatic logic [31:0] data_of(input logic [31:0] pc);
        return 32'h1000_0000 + {24'h0, addr_of(pc)};
    endfunction

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        req_q.delete();
        acc_pc.delete();
        acc_in.delete();
    endtask

    // One clock: memory responder, output checks against the model, then the model's view of the edge.
    task automatic cyc();
        logic exp_req;
        im_valid = mbusy && cyc_n == mresp;
        im_rdata = im_valid ? 32'h1000_0000 + {24'h0, maddr} : $urandom;
        #1;
        chk(inst_valid, m_q.size() != 0, "inst_valid");
        if (m_q.size() != 0) begin
            chk(inst_pc, m_q[0][63:32], "inst_pc");
            chk(inst, m_q[0][31:0], "inst");
        end
        exp_req = rst && !m_out && m_q.size() < DEPTH && !redirect;
        chk(im_req, exp_req, "im_req");
        if (exp_req) chk(im_addr, addr_of(m_pc), "im_addr");
        else if (rst && m_out) chk(im_addr, maddr, "im_addr_hold");
        if (rst && !redirect && inst_valid && inst_ready) begin
            acc_pc.push_back(inst_pc);
            acc_in.push_back(inst);
        end
        if (im_req) req_q.push_back(im_addr);
        if (im_valid) mbusy = 0;
        if (im_req) begin
            mbusy = 1;
            mresp = cyc_n + lat;
            maddr = im_addr;
        end
        if (!rst) begin
            m_q.delete();
            m_pc = RESET_PC;
            m_out = 0;
            m_drop = 0;
        end else if (redirect) begin
            m_q.delete();
            m_pc = redirect_pc & ~32'h3;
            if (im_valid) begin
                m_out = 0;
                m_drop = 0;
            end else if (m_out) m_drop = 1;
        end else begin
            if (m_q.size() != 0 && inst_ready) void'(m_q.pop_front());
            if (m_out && im_valid) begin
                if (!m_drop) begin
                    m_q.push_back({m_pc, data_of(m_pc)});
                    m_pc = m_pc + 32'd4;
                end
                m_out = 0;
                m_drop = 0;
            end
            if (exp_req) m_out = 1;
        end
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic do_reset();
        rst = 0;
        redirect = 0;
        repeat (2) cyc();
        chk(inst, 32'h0, "rst_inst");
        chk(inst_pc, 32'h0, "rst_inst_pc");
        chk(inst_valid, 1'b0, "rst_inst_valid");
        rst = 1;
        clear_logs();
    endtask

    initial begin
        // Step 1: sequential fetch with 1-cycle memory
        do_reset();
        inst_ready = 1;
        lat = 1;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (first < 0 && inst_valid) first = i + 1;
        end
        chk(first, 2, "t1_first_valid");
        chk(32'(req_q.size() >= 3 && acc_pc.size() >= 3), 1, "t1_counts");
        if (req_q.size() >= 3 && acc_pc.size() >= 3) begin
            for (int i = 0; i < 3; i++) begin
                chk(req_q[i], 8'(i), "t1_im_addr");
                chk(acc_pc[i], RESET_PC + 32'(4 * i), "t1_inst_pc");
                chk(acc_in[i], 32'h1000_0000 + 32'(i), "t1_inst");
            end
        end

        // Step 2: backpressure fills the queue, then drain
        inst_ready = 0;
        do_reset();
        repeat (20) cyc();
        chk(32'(req_q.size()), 4, "t2_fill_reqs");
        chk(im_req, 1'b0, "t2_req_stall");
        chk(inst_pc, RESET_PC, "t2_head_held");
        inst_ready = 1;
        clear_logs();
        repeat (12) cyc();
        chk(32'(acc_pc.size() >= 4 && req_q.size() >= 1), 1, "t2_drain_counts");
        if (acc_pc.size() >= 4 && req_q.size() >= 1) begin
            for (int i = 0; i < 4; i++) chk(acc_pc[i], RESET_PC + 32'(4 * i), "t2_drain_pc");
            chk(req_q[0], 8'h04, "t2_resume_addr");
        end

        // Step 3: redirect while a slow response is outstanding
        do_reset();
        lat = 3;
        done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (req_q.size() == 3) done = 1;
            else cyc();
        end
        chk(done, 1'b1, "t3_reach_req2");
        redirect = 1;
        redirect_pc = 32'h0000_3041;
        clear_logs();
        cyc();
        redirect = 0;
        chk(inst_valid, 1'b0, "t3_flush");
        repeat (14) cyc();
        chk(32'(req_q.size() >= 1 && acc_pc.size() >= 1), 1, "t3_counts");
        if (req_q.size() >= 1 && acc_pc.size() >= 1) begin
            chk(req_q[0], 8'h10, "t3_next_addr");
            chk(acc_pc[0], 32'h0000_3040, "t3_next_pc");
        end

        // Step 4: redirect coincident with a response while two entries wait
        inst_ready = 0;
        do_reset();
        lat = 2;
        done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (m_q.size() == 2 && mbusy && mresp == cyc_n) done = 1;
            else cyc();
        end
        chk(done, 1'b1, "t4_reach");
        inst_ready = 1;
        redirect = 1;
        redirect_pc = 32'h0000_3100;
        clear_logs();
        cyc();
        redirect = 0;
        chk(inst_valid, 1'b0, "t4_flush");
        repeat (10) cyc();
        chk(32'(req_q.size() >= 1 && acc_pc.size() >= 1), 1, "t4_counts");
        if (req_q.size() >= 1 && acc_pc.size() >= 1) begin
            chk(req_q[0], 8'h40, "t4_next_addr");
            chk(acc_pc[0], 32'h0000_3100, "t4_next_pc");
        end

        // Step 5: reset mid-WAIT, stale response lands right after
        do_reset();
        lat = 2;
        cyc();
        rst = 0;
        cyc();
        rst = 1;
        clear_logs();
        cyc();
        chk(inst_valid, 1'b0, "t5_stale_ignored");
        repeat (8) cyc();
        chk(32'(req_q.size() >= 1 && acc_pc.size() >= 1), 1, "t5_counts");
        if (req_q.size() >= 1 && acc_pc.size() >= 1) begin
            chk(req_q[0], 8'h00, "t5_restart_addr");
            chk(acc_pc[0], RESET_PC, "t5_restart_pc");
        end

        // Step 6: window wrap of im_addr
        lat = 1;
        redirect = 1;
        redirect_pc = 32'h0000_33FC;
        repeat (3) cyc();
        clear_logs();
        cyc();
        redirect = 0;
        repeat (8) cyc();
        chk(32'(req_q.size() >= 2 && acc_pc.size() >= 2), 1, "t6_counts");
        if (req_q.size() >= 2 && acc_pc.size() >= 2) begin
            chk(req_q[0], 8'hFF, "t6_addr_ff");
            chk(req_q[1], 8'h00, "t6_addr_wrap");
            chk(acc_pc[0], 32'h0000_33FC, "t6_pc0");
            chk(acc_pc[1], 32'h0000_3400, "t6_pc1");
            chk(acc_in[1], 32'h1000_0000, "t6_inst_wrap");
        end

        // Random traffic: backpressure, redirects and memory latency
        repeat (3000) begin
            inst_ready = $urandom_range(0, 3) != 0;
            redirect = $urandom_range(0, 15) == 0;
            redirect_pc = RESET_PC + $urandom_range(0, 2047);
            lat = $urandom_range(1, 4);
            cyc();
        end
        redirect = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
